pc_fetch: RTL and testbench

Instruction-fetch front end that owns the program counter. It drives pc_o into the PC+4 adder and takes the adder's pc_four result back as the sequential next PC. It issues requests to a synchronous-read instruction memory and delivers {pc, instr} pairs to decode over a valid/ready handshake. It also handles branch/jump redirects, including flushing of instructions already in flight.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/pc_fetch_if.sv | 12 +
 rtl/fetch_skid.sv | 36 +++
 rtl/pc_fetch.sv | 128 ++++++++++++
 tb/tb_pc_fetch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared fetch types and constants: reset defaults, FSM states, fetch packet.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_pkt_t;

  // Word-align a redirect target
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-to-decode valid/ready handshake carrying one {pc, instr} pair.
interface pc_fetch_if;
  import rv_pkg::*;

  logic            if_valid_o;
  logic            if_ready_i;
  logic [XLEN-1:0] if_pc_o;
  logic [XLEN-1:0] if_instr_o;

  modport master (output if_valid_o, output if_pc_o, output if_instr_o, input if_ready_i);
  modport slave  (input if_valid_o, input if_pc_o, input if_instr_o, output if_ready_i);
endinterface

// File: rtl/fetch_skid.sv
// Single-entry skid buffer for returning fetch packets; push wins over pop.
module fetch_skid
  import rv_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    i_push,
  input  logic    i_pop,
  input  logic    i_flush,
  input  if_pkt_t i_data,
  output if_pkt_t o_data,
  output logic    o_valid
);

  logic    r_valid;
  if_pkt_t r_data;

  // Entry storage: flush clears, push (re)loads, pop empties
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues imem requests, delivers
// {pc, instr} to decode and flushes in-flight work on redirects.
module pc_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_four_i,
  output logic [XLEN-1:0] pc_o,
  output logic            imem_req_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  pc_fetch_if.master      dec,
  output logic            misalign_o
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic            r_valid;
  logic            r_misalign;
  if_pkt_t         r_out;

  logic            w_req;
  logic            w_fire;
  logic            w_out_free;
  logic            w_skid_valid;
  logic            w_skid_push;
  logic            w_skid_pop;
  if_pkt_t         w_skid_data;
  if_pkt_t         w_ret_pkt;

  assign w_fire     = r_valid & dec.if_ready_i;
  assign w_out_free = ~r_valid | w_fire;
  assign w_ret_pkt  = '{pc: r_inflight_pc, instr: imem_rdata_i};
  // Skid refills the output first; return data then takes the skid slot
  assign w_skid_pop  = ~br_taken_i & w_skid_valid & w_out_free;
  assign w_skid_push = ~br_taken_i & r_inflight & (w_skid_pop | ~w_out_free);

  fetch_skid u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_flush (br_taken_i),
    .i_data  (w_ret_pkt),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= BOOT;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: redirects always land in RUN
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     if (w_skid_push) w_state_nxt = HOLD;
      HOLD:    if (br_taken_i || (w_skid_pop && !w_skid_push)) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // FSM output: request only when the returning word is guaranteed a slot
  always_comb begin
    w_req = (r_state == RUN) && !br_taken_i && !w_skid_valid &&
            (!r_valid || dec.if_ready_i || !r_inflight);
  end

  // PC, in-flight tracking and misalignment pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_misalign <= br_taken_i && (br_target_i[1:0] != 2'b00);
      if (br_taken_i) begin
        r_pc       <= align_pc(br_target_i);
        r_inflight <= 1'b0;
      end else if (w_req) begin
        r_pc          <= pc_four_i;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  // Decode-facing output register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_out   <= '{pc: '0, instr: NOP_INSTR};
    end else if (br_taken_i) begin
      r_valid     <= 1'b0;
      r_out.instr <= NOP_INSTR;
    end else if (w_skid_pop) begin
      r_valid <= 1'b1;
      r_out   <= w_skid_data;
    end else if (r_inflight && w_out_free) begin
      r_valid <= 1'b1;
      r_out   <= w_ret_pkt;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign pc_o           = r_pc;
  assign imem_req_o     = w_req;
  assign misalign_o     = r_misalign;
  assign dec.if_valid_o = r_valid;
  assign dec.if_pc_o    = r_out.pc;
  assign dec.if_instr_o = r_out.instr;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: stimulus queues expected {pc, instr} pairs,
// a monitor pops and compares on every decode transfer.
module tb_pc_fetch;
  import rv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        br;
  logic [31:0] br_tgt;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        misalign;

  int      n_checks;
  int      n_fails;
  int      cyc = 0;
  int      t0;
  int      t1;
  if_pkt_t exp_q[$];

  pc_fetch_if dec_if();

  pc_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_four_i    (pc_four),
    .pc_o         (pc),
    .imem_req_o   (imem_req),
    .imem_rdata_i (imem_rdata),
    .br_taken_i   (br),
    .br_target_i  (br_tgt),
    .dec          (dec_if),
    .misalign_o   (misalign)
  );

  // External PC+4 adder
  assign pc_four = pc + 32'd4;

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word = addr ^ A5A5_0000
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req) imem_rdata <= pc ^ 32'hA5A5_0000;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back('{pc: p, instr: i});
  endtask

  // Transfers complete on the next rising edge; judge them at the falling edge
  task automatic monitor();
    if_pkt_t e;
    forever begin
      @(negedge clk);
      if (!rst && dec_if.if_valid_o && dec_if.if_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_xfer: got pc %h instr %h, expected none", dec_if.if_pc_o, dec_if.if_instr_o);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pc", dec_if.if_pc_o, e.pc);
          chk("xfer_instr", dec_if.if_instr_o, e.instr);
        end
      end
    end
  endtask

  task automatic wait_valid(output int t);
    int k;
    t = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (dec_if.if_valid_o) break;
    end
    t = cyc;
    if (k == 40) begin
      n_checks++; n_fails++;
      $display("FAIL wait_valid: timeout, if_valid_o got 0 expected 1");
    end
  endtask

  task automatic drain(output int t);
    int k;
    t = 0;
    for (k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    t = cyc;
    if (exp_q.size() != 0) begin
      n_checks++; n_fails++;
      $display("FAIL drain: timeout, %0d outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    @(posedge clk); #1;
    br = 1'b1; br_tgt = tgt;
    @(posedge clk); #1;
    br = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; br = 1'b0; br_tgt = '0;
    dec_if.if_ready_i = 1'b0;
    n_checks = 0; n_fails = 0;
    fork monitor(); join_none

    // Reset values
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(dec_if.if_valid_o), 32'h0);
    chk("rst_if_pc", dec_if.if_pc_o, 32'h0);
    chk("rst_instr", dec_if.if_instr_o, NOP);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);

    // 1: boot then 1 instr/cycle
    @(posedge clk); #1;
    rst = 1'b0; dec_if.if_ready_i = 1'b1;
    @(negedge clk); #1 chk("boot_req_c1", 32'(imem_req), 32'h0);
    @(negedge clk); #1 chk("boot_req_c2", 32'(imem_req), 32'h1);
    chk("boot_req_pc", pc, 32'h0);
    push_exp(32'h0, 32'hA5A5_0000);
    push_exp(32'h4, 32'hA5A5_0004);
    wait_valid(t0);
    drain(t1);
    chk("tput_0_4", 32'(t1 - t0), 32'd1);
    @(posedge clk); #1 dec_if.if_ready_i = 1'b0;

    // 2: backpressure with PC 8 on the output, C goes to the skid
    push_exp(32'h8,  32'hA5A5_0008);
    push_exp(32'hC,  32'hA5A5_000C);
    push_exp(32'h10, 32'hA5A5_0010);
    repeat (3) begin
      @(negedge clk); #1;
      chk("hold_valid", 32'(dec_if.if_valid_o), 32'h1);
      chk("hold_pc", dec_if.if_pc_o, 32'h8);
      chk("hold_req", 32'(imem_req), 32'h0);
    end
    @(posedge clk); #1 dec_if.if_ready_i = 1'b1;
    drain(t1);

    // 3: redirect to 0x100 while 0x14 sits on the output and 0x18 returns
    @(posedge clk); #1;
    dec_if.if_ready_i = 1'b0; br = 1'b1; br_tgt = 32'h0000_0100;
    @(posedge clk); #1 br = 1'b0;
    @(negedge clk); #1;
    chk("flush_valid", 32'(dec_if.if_valid_o), 32'h0);
    chk("flush_instr", dec_if.if_instr_o, NOP);
    chk("flush_pc", pc, 32'h100);
    chk("aligned_misalign", 32'(misalign), 32'h0);
    @(negedge clk); #1 chk("aligned_misalign2", 32'(misalign), 32'h0);
    push_exp(32'h100, 32'hA5A5_0100);
    dec_if.if_ready_i = 1'b1;
    drain(t1);
    @(posedge clk); #1 dec_if.if_ready_i = 1'b0;

    // 4: misaligned redirect, then back-to-back redirects (last wins)
    br = 1'b1; br_tgt = 32'h0000_0102;
    @(posedge clk); #1 br = 1'b0;
    @(negedge clk); #1;
    chk("misalign_pulse", 32'(misalign), 32'h1);
    chk("misalign_pc", pc, 32'h100);
    @(negedge clk); #1 chk("misalign_clear", 32'(misalign), 32'h0);
    push_exp(32'h100, 32'hA5A5_0100);
    dec_if.if_ready_i = 1'b1;
    drain(t1);
    @(posedge clk); #1 dec_if.if_ready_i = 1'b0;
    br = 1'b1; br_tgt = 32'h0000_0200;
    @(posedge clk); #1 br_tgt = 32'h0000_0300;
    @(posedge clk); #1 br = 1'b0;
    push_exp(32'h300, 32'hA5A5_0300);
    dec_if.if_ready_i = 1'b1;
    drain(t1);
    @(posedge clk); #1 dec_if.if_ready_i = 1'b0;

    // 5: PC wrap past the top of the address space
    push_exp(32'hFFFF_FFF8, 32'h5A5A_FFF8);
    push_exp(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    push_exp(32'h0000_0000, 32'hA5A5_0000);
    redirect(32'hFFFF_FFF8);
    dec_if.if_ready_i = 1'b1;
    wait_valid(t0);
    drain(t1);
    chk("tput_wrap", 32'(t1 - t0), 32'd2);
    @(posedge clk); #1 dec_if.if_ready_i = 1'b0;

    // 6: async reset with output valid and skid full
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(dec_if.if_valid_o), 32'h1);
    chk("pre_rst_req", 32'(imem_req), 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_valid", 32'(dec_if.if_valid_o), 32'h0);
    chk("async_rst_if_pc", dec_if.if_pc_o, 32'h0);
    chk("async_rst_instr", dec_if.if_instr_o, NOP);
    chk("async_rst_req", 32'(imem_req), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; dec_if.if_ready_i = 1'b1;
    push_exp(32'h0, 32'hA5A5_0000);
    push_exp(32'h4, 32'hA5A5_0004);
    drain(t1);
    @(posedge clk); #1 dec_if.if_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
